// File: rtl/weight_fetch.sv
// rtl/weight_fetch.sv - walks a kernel opcode range through the weight ROM and streams 270-bit kernel beats
module weight_fetch #(
    parameter int OPW         = 6,
    parameter int WW          = 90,
    parameter int NUM_KERNELS = 38
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [OPW-1:0]    i_base,
    input  logic [OPW:0]      i_count,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [OPW-1:0]    o_opcode,
    input  logic [WW-1:0]     i_weight0,
    input  logic [WW-1:0]     i_weight1,
    input  logic [WW-1:0]     i_weight2,
    output logic              o_kernel_valid,
    input  logic              i_kernel_ready,
    output logic [3*WW-1:0]   o_kernel_data,
    output logic [OPW-1:0]    o_kernel_idx
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    localparam logic [OPW+1:0] NK      = (OPW+2)'(NUM_KERNELS);
    localparam logic [OPW-1:0] ONE_OP  = 1;
    localparam logic [OPW:0]   ONE_CNT = 1;

    state_t           state;
    logic [OPW-1:0]   ptr;
    logic [OPW:0]     remaining;
    logic [OPW+1:0]   range_end;
    logic             load;

    // Two extra bits so base + count can never overflow before the range check.
    assign range_end = {2'b00, i_base} + {1'b0, i_count};
    assign load      = !o_kernel_valid || i_kernel_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= S_IDLE;
            ptr            <= '0;
            remaining      <= '0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_err          <= 1'b0;
            o_opcode       <= '0;
            o_kernel_valid <= 1'b0;
            o_kernel_data  <= '0;
            o_kernel_idx   <= '0;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        if (range_end > NK) begin
                            o_err <= 1'b1;
                        end else if (i_count == '0) begin
                            o_busy <= 1'b1;
                            o_done <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            ptr       <= i_base;
                            remaining <= i_count;
                            o_opcode  <= i_base;
                            o_busy    <= 1'b1;
                            state     <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    // The ROM is combinational, so the rows for o_opcode are captured directly.
                    if (load) begin
                        o_kernel_data  <= {i_weight0, i_weight1, i_weight2};
                        o_kernel_idx   <= o_opcode;
                        o_kernel_valid <= 1'b1;
                        ptr            <= ptr + ONE_OP;
                        remaining      <= remaining - ONE_CNT;
                        if (remaining == ONE_CNT) begin
                            state <= S_DRAIN;
                        end else begin
                            o_opcode <= ptr + ONE_OP;
                        end
                    end
                end
                S_DRAIN: begin
                    if (i_kernel_ready) begin
                        o_kernel_valid <= 1'b0;
                        o_done         <= 1'b1;
                        state          <= S_DONE;
                    end
                end
                S_DONE: begin
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_fetch.sv
// tb/tb_weight_fetch.sv - scoreboard bench for weight_fetch with a behavioural weight ROM
module tb_weight_fetch;

    localparam int OPW = 6;
    localparam int WW  = 90;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [OPW-1:0]    base = '0;
    logic [OPW:0]      count = '0;
    logic              busy, done, err;
    logic [OPW-1:0]    opcode;
    logic [WW-1:0]     w0, w1, w2;
    logic              kvalid;
    logic              kready = 1'b1;
    logic [3*WW-1:0]   kdata;
    logic [OPW-1:0]    kidx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [WW-1:0] rom_row(input logic [OPW-1:0] op, input int r);
        if (op == 6'd0)
            return (r == 0) ? 90'h28647515897477928427 : (r == 1) ? 90'h60594996201193271552 : 90'h47266548480648402887;
        if (op == 6'd5)
            return (r == 0) ? 90'h47960925501117460540 : (r == 1) ? 90'h39427439177933840030 : 90'h81112499580452573516;
        if (op == 6'd10)
            return (r == 0) ? 90'h92519984257157180798 : (r == 1) ? 90'h89831748063488704444 : 90'h42330312885108666749;
        if (op == 6'd37)
            return (r == 0) ? 90'h55586487683777192405 : (r == 1) ? 90'h43289669156736432285 : 90'h25241410316819854735;
        return {30'(int'(op) * 7 + r + 1), 30'(32'h9E3779B9 ^ (32'(op) << r)), 30'(int'(op) + 100 * r)};
    endfunction

    function automatic logic [3*WW-1:0] exp_beat(input logic [OPW-1:0] op);
        return {rom_row(op, 0), rom_row(op, 1), rom_row(op, 2)};
    endfunction

    assign w0 = rom_row(opcode, 0);
    assign w1 = rom_row(opcode, 1);
    assign w2 = rom_row(opcode, 2);

    weight_fetch #(.OPW(OPW), .WW(WW), .NUM_KERNELS(38)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_start        (start),
        .i_base         (base),
        .i_count        (count),
        .o_busy         (busy),
        .o_done         (done),
        .o_err          (err),
        .o_opcode       (opcode),
        .i_weight0      (w0),
        .i_weight1      (w1),
        .i_weight2      (w2),
        .o_kernel_valid (kvalid),
        .i_kernel_ready (kready),
        .o_kernel_data  (kdata),
        .o_kernel_idx   (kidx)
    );

    // Monitor: logs every handshake and flags any change of a stalled beat.
    logic [OPW-1:0]   got_idx[$];
    logic [3*WW-1:0]  got_data[$];
    int               done_n = 0;
    int               err_n = 0;
    int               stall_viol = 0;
    logic             prev_stall = 1'b0;
    logic [3*WW-1:0]  held_data = '0;
    logic [OPW-1:0]   held_idx = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (kvalid && kready) begin
                got_idx.push_back(kidx);
                got_data.push_back(kdata);
            end
            if (done) done_n <= done_n + 1;
            if (err) err_n <= err_n + 1;
            if (prev_stall && (!kvalid || kdata !== held_data || kidx !== held_idx))
                stall_viol <= stall_viol + 1;
        end
        prev_stall <= rst_n && kvalid && !kready;
        held_data  <= kdata;
        held_idx   <= kidx;
    end

    logic [OPW-1:0] exp_q[$];
    int rd = 0;

    task automatic issue(input logic [OPW-1:0] b, input logic [OPW:0] c);
        @(posedge clk); #1;
        start = 1'b1; base = b; count = c;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_flags: busy=%b done=%b err=%b, required 0", busy, done, err); end
        checks++; if (kvalid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", kvalid); end
        checks++; if (opcode !== '0 || kidx !== '0 || kdata !== '0) begin errors++; $display("FAIL reset_regs: opcode=%0d idx=%0d data=%h, required 0", opcode, kidx, kdata); end
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        logic [OPW-1:0] e;
        exp_q.push_back(6'd0);
        issue(6'd0, 7'd1);
        checks++; if (busy !== 1'b1 || opcode !== 6'd0 || kvalid !== 1'b0) begin errors++; $display("FAIL single_n1: busy=%b opcode=%0d valid=%b, required 1/0/0", busy, opcode, kvalid); end
        @(posedge clk); #1;
        checks++; if (kvalid !== 1'b1 || kidx !== 6'd0 || kdata !== exp_beat(6'd0)) begin errors++; $display("FAIL single_n2: valid=%b idx=%0d data=%h, required 1/0/%h", kvalid, kidx, kdata, exp_beat(6'd0)); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b1 || kvalid !== 1'b0) begin errors++; $display("FAIL single_n3: done=%b valid=%b, required 1/0", done, kvalid); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL single_n4: busy=%b done=%b, required 0/0", busy, done); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd >= got_idx.size()) begin errors++; $display("FAIL single_sb: missing beat, required idx %0d", e); end
            else begin
                if (got_idx[rd] !== e || got_data[rd] !== exp_beat(e)) begin errors++; $display("FAIL single_sb: got idx %0d data %h, required idx %0d data %h", got_idx[rd], got_data[rd], e, exp_beat(e)); end
                rd++;
            end
        end
        checks++; if (got_idx.size() != rd) begin errors++; $display("FAIL single_extra: %0d beats, required %0d", got_idx.size(), rd); rd = got_idx.size(); end
    endtask

    task automatic test_full_sweep;
        logic [OPW-1:0] e;
        int bubbles = 0;
        int d0 = done_n;
        for (int i = 0; i < 38; i++) exp_q.push_back(6'(i));
        issue(6'd0, 7'd38);
        for (int i = 0; i < 38; i++) begin
            @(posedge clk); #1;
            if (!kvalid) bubbles++;
        end
        checks++; if (bubbles != 0) begin errors++; $display("FAIL sweep_bubbles: got %0d, required 0", bubbles); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL sweep_done: got %b, required 1", done); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || done_n - d0 != 1) begin errors++; $display("FAIL sweep_end: busy=%b dones=%0d, required 0/1", busy, done_n - d0); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd >= got_idx.size()) begin errors++; $display("FAIL sweep_sb: missing beat, required idx %0d", e); end
            else begin
                if (got_idx[rd] !== e || got_data[rd] !== exp_beat(e)) begin errors++; $display("FAIL sweep_sb: got idx %0d data %h, required idx %0d data %h", got_idx[rd], got_data[rd], e, exp_beat(e)); end
                rd++;
            end
        end
        checks++; if (got_idx.size() != rd) begin errors++; $display("FAIL sweep_extra: %0d beats, required %0d", got_idx.size(), rd); rd = got_idx.size(); end
    endtask

    task automatic test_backpressure;
        logic [OPW-1:0] e;
        logic pat[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        int s0 = stall_viol;
        int d0 = done_n;
        for (int i = 5; i < 9; i++) exp_q.push_back(6'(i));
        issue(6'd5, 7'd4);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            kready = pat[k];
            if (k == 1) begin
                checks++; if (kvalid !== 1'b1 || kidx !== 6'd6 || kdata !== exp_beat(6'd6)) begin errors++; $display("FAIL bp_stall: valid=%b idx=%0d, required 1/6", kvalid, kidx); end
            end
        end
        kready = 1'b1;
        for (int c = 0; c < 20 && done_n == d0; c++) @(posedge clk);
        checks++; if (done_n == d0) begin errors++; $display("FAIL bp_timeout: no done, required 1"); end
        checks++; if (stall_viol != s0) begin errors++; $display("FAIL bp_stable: %0d stall changes, required 0", stall_viol - s0); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd >= got_idx.size()) begin errors++; $display("FAIL bp_sb: missing beat, required idx %0d", e); end
            else begin
                if (got_idx[rd] !== e || got_data[rd] !== exp_beat(e)) begin errors++; $display("FAIL bp_sb: got idx %0d data %h, required idx %0d data %h", got_idx[rd], got_data[rd], e, exp_beat(e)); end
                rd++;
            end
        end
        checks++; if (got_idx.size() != rd) begin errors++; $display("FAIL bp_extra: %0d beats, required %0d", got_idx.size(), rd); rd = got_idx.size(); end
    endtask

    task automatic test_range_errors;
        logic [OPW-1:0] e;
        int d0;
        int e0 = err_n;
        issue(6'd36, 7'd3);
        checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL err_pulse: err=%b busy=%b, required 1/0", err, busy); end
        @(posedge clk); #1;
        checks++; if (err !== 1'b0 || busy !== 1'b0 || kvalid !== 1'b0) begin errors++; $display("FAIL err_after: err=%b busy=%b valid=%b, required 0/0/0", err, busy, kvalid); end
        checks++; if (got_idx.size() != rd) begin errors++; $display("FAIL err_beats: %0d beats, required %0d", got_idx.size(), rd); rd = got_idx.size(); end

        d0 = done_n;
        exp_q.push_back(6'd37);
        issue(6'd37, 7'd1);
        for (int c = 0; c < 20 && done_n == d0; c++) @(posedge clk);
        checks++; if (done_n == d0) begin errors++; $display("FAIL last_timeout: no done, required 1"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd >= got_idx.size()) begin errors++; $display("FAIL last_sb: missing beat, required idx %0d", e); end
            else begin
                if (got_idx[rd] !== e || got_data[rd] !== exp_beat(e)) begin errors++; $display("FAIL last_sb: got idx %0d data %h, required idx %0d data %h", got_idx[rd], got_data[rd], e, exp_beat(e)); end
                rd++;
            end
        end
        checks++; if (got_idx.size() != rd) begin errors++; $display("FAIL last_extra: %0d beats, required %0d", got_idx.size(), rd); rd = got_idx.size(); end

        @(posedge clk); #1;
        issue(6'd3, 7'd0);
        checks++; if (done !== 1'b1 || busy !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL zero_n1: done=%b busy=%b err=%b, required 1/1/0", done, busy, err); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_n2: done=%b busy=%b, required 0/0", done, busy); end
        checks++; if (got_idx.size() != rd || err_n - e0 != 1) begin errors++; $display("FAIL zero_side: beats=%0d errs=%0d, required %0d/1", got_idx.size(), err_n - e0, rd); rd = got_idx.size(); end
    endtask

    task automatic test_start_while_busy;
        logic [OPW-1:0] e;
        int d0 = done_n;
        int e0 = err_n;
        for (int i = 12; i < 17; i++) exp_q.push_back(6'(i));
        issue(6'd12, 7'd5);
        @(posedge clk); #1;
        start = 1'b1; base = 6'd0; count = 7'd2;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 30 && done_n == d0; c++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (done_n - d0 != 1 || err_n != e0 || busy !== 1'b0) begin errors++; $display("FAIL busy_start: dones=%0d errs=%0d busy=%b, required 1/0/0", done_n - d0, err_n - e0, busy); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd >= got_idx.size()) begin errors++; $display("FAIL busy_sb: missing beat, required idx %0d", e); end
            else begin
                if (got_idx[rd] !== e || got_data[rd] !== exp_beat(e)) begin errors++; $display("FAIL busy_sb: got idx %0d data %h, required idx %0d data %h", got_idx[rd], got_data[rd], e, exp_beat(e)); end
                rd++;
            end
        end
        checks++; if (got_idx.size() != rd) begin errors++; $display("FAIL busy_extra: %0d beats, required %0d", got_idx.size(), rd); rd = got_idx.size(); end
    endtask

    task automatic test_mid_reset;
        logic [OPW-1:0] e;
        int d0 = done_n;
        int c;
        exp_q.push_back(6'd20);
        exp_q.push_back(6'd21);
        issue(6'd20, 7'd6);
        for (c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            if (got_idx.size() - rd >= 2) break;
        end
        checks++; if (c >= 20) begin errors++; $display("FAIL rst_timeout: %0d beats, required 2", got_idx.size() - rd); end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || kvalid !== 1'b0) begin errors++; $display("FAIL rst_async_flags: busy=%b done=%b err=%b valid=%b, required 0", busy, done, err, kvalid); end
        checks++; if (opcode !== '0 || kidx !== '0 || kdata !== '0) begin errors++; $display("FAIL rst_async_regs: opcode=%0d idx=%0d data=%h, required 0", opcode, kidx, kdata); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (done_n != d0) begin errors++; $display("FAIL rst_no_done: dones=%0d, required 0", done_n - d0); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd >= got_idx.size()) begin errors++; $display("FAIL rst_sb: missing beat, required idx %0d", e); end
            else begin
                if (got_idx[rd] !== e || got_data[rd] !== exp_beat(e)) begin errors++; $display("FAIL rst_sb: got idx %0d data %h, required idx %0d data %h", got_idx[rd], got_data[rd], e, exp_beat(e)); end
                rd++;
            end
        end
        checks++; if (got_idx.size() != rd) begin errors++; $display("FAIL rst_extra: %0d beats, required %0d", got_idx.size(), rd); rd = got_idx.size(); end

        exp_q.push_back(6'd10);
        issue(6'd10, 7'd1);
        for (c = 0; c < 20 && done_n == d0; c++) @(posedge clk);
        checks++; if (done_n == d0) begin errors++; $display("FAIL rst_restart_timeout: no done, required 1"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd >= got_idx.size()) begin errors++; $display("FAIL restart_sb: missing beat, required idx %0d", e); end
            else begin
                if (got_idx[rd] !== e || got_data[rd] !== exp_beat(e)) begin errors++; $display("FAIL restart_sb: got idx %0d data %h, required idx %0d data %h", got_idx[rd], got_data[rd], e, exp_beat(e)); end
                rd++;
            end
        end
        checks++; if (got_idx.size() != rd) begin errors++; $display("FAIL restart_extra: %0d beats, required %0d", got_idx.size(), rd); rd = got_idx.size(); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_sweep();
        test_backpressure();
        test_range_errors();
        test_start_while_busy();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/weight_fetch.md
Name: weight_fetch

Overview:
- Sequencer on the consumer side of the weight ROM interface.
- On command, it walks a contiguous range of kernel opcodes and drives o_opcode to the combinational weight ROM. It captures the three 90-bit weight rows returned for each opcode.
- It streams each kernel as one 270-bit beat over a valid/ready handshake to the depthwise conv engine, and holds data under backpressure.

Parameters:
- OPW, 6, opcode width.
- WW, 90, width of one weight row.
- NUM_KERNELS, 38, number of valid opcodes (0..NUM_KERNELS-1).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle command strobe.
- i_base  in  OPW  first opcode of the range.
- i_count  in  OPW+1  number of kernels to fetch.
- o_busy  out  1  high from command acceptance until o_done.
- o_done  out  1  one-cycle pulse at end of range.
- o_err  out  1  one-cycle pulse when a command is rejected.
- o_opcode  out  OPW  registered opcode to the ROM.
- i_weight0  in  WW  ROM row 0.
- i_weight1  in  WW  ROM row 1.
- i_weight2  in  WW  ROM row 2.
- o_kernel_valid  out  1  output beat valid.
- i_kernel_ready  in  1  consumer ready.
- o_kernel_data  out  3*WW  {row0,row1,row2}; row0 in bits [3*WW-1:2*WW].
- o_kernel_idx  out  OPW  opcode that produced the current beat.

Behaviour:
- Reset (asynchronous, i_rst_n=0):
  - state IDLE.
  - o_busy, o_done, o_err, o_kernel_valid = 0.
  - o_opcode, o_kernel_idx, o_kernel_data = 0.
  - Internal ptr and remaining counters = 0.
  - Reset asserted mid-operation aborts the transfer immediately. No o_done is produced. The beat in flight is lost.
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE, on i_start=1:
  - If i_base + i_count > NUM_KERNELS (evaluated at OPW+2 bits): pulse o_err next cycle and stay IDLE.
  - Else if i_count == 0: go to DONE. o_busy pulses with o_done; no beats are issued.
  - Else: ptr = i_base, remaining = i_count, o_opcode = i_base, o_busy = 1, go to FETCH.
- i_start while o_busy=1 is ignored, without o_err.
- FETCH:
  - The ROM is combinational, so the weights for o_opcode are valid in the same cycle.
  - Load condition: o_kernel_valid==0 OR i_kernel_ready==1.
  - On load, next edge:
    - o_kernel_data = {i_weight0,i_weight1,i_weight2}.
    - o_kernel_idx = o_opcode.
    - o_kernel_valid = 1.
    - ptr += 1, o_opcode = ptr+1, remaining -= 1.
  - If remaining becomes 0, go to DRAIN. o_opcode holds the last issued value and does not advance past the range.
  - Without the load condition, all registers hold. o_kernel_data must stay stable while valid && !ready.
- DRAIN:
  - On i_kernel_ready=1: o_kernel_valid = 0 at the next edge, go to DONE.
- DONE:
  - o_done = 1 for exactly one cycle, o_busy = 0 at the next edge, then IDLE.
  - A new i_start is accepted from the IDLE cycle after DONE.
- Latency and throughput:
  - i_start at cycle N → o_opcode=i_base at N+1 → first o_kernel_valid at N+2.
  - Throughput is 1 beat/cycle with i_kernel_ready held high.
  - o_done occurs 1 cycle after the final handshake cycle.
- Handshake rules:
  - A transfer occurs when valid && ready on a rising edge.
  - o_kernel_valid never drops without a transfer.
  - ready toggling never duplicates or drops a beat. Beats leave in strictly ascending opcode order.
- Range boundaries:
  - The last legal opcode NUM_KERNELS-1 is fetched normally.
  - ptr never wraps, guaranteed by the start check.
- o_opcode changes only on a load or on command acceptance. This keeps the ROM output stable for the captured beat.

Test Plan:
- Single kernel: start base=0 count=1, ready=1 → at N+2, 1 beat:
  - idx=0.
  - data = {90'h28647515897477928427, 90'h60594996201193271552, 90'h47266548480648402887}.
  - o_done at N+3; o_busy low after.
- Full sweep: base=0 count=38, ready=1 → 38 consecutive beats, idx 0..37.
  - Beat 37 = {90'h55586487683777192405, 90'h43289669156736432285, 90'h25241410316819854735}.
  - One o_done; no bubbles.
- Backpressure: base=5 count=4, ready pattern 1,0,0,1,0,1,1,1 → exactly 4 beats, idx 5,6,7,8.
  - Data stable during stalls; beat idx 5 = {90'h47960925501117460540, 90'h39427439177933840030, 90'h81112499580452573516}.
- Range errors:
  - base=36 count=3 → o_err pulse, o_busy stays 0, no beats.
  - base=37 count=1 → accepted, one beat idx=37.
  - count=0 → o_done pulse, no beats, no o_err.
- Start while busy: second i_start during an active range → ignored. The original range completes unchanged.
- Mid-operation reset: assert i_rst_n=0 after 2 of 6 beats → all outputs 0 asynchronously, no o_done. A new start base=10 count=1 after release → beat idx=10 = {90'h92519984257157180798, 90'h89831748063488704444, 90'h42330312885108666749}.
